// File: rtl/branch_ctrl.sv
// EX-stage branch resolution, fetch PC register, redirect flush and misaligned-target trap.
// Optional branch statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_branch,
    input  logic        i_ex_is_jal,
    input  logic        i_ex_is_jalr,
    input  logic [2:0]  i_ex_funct3,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_imm,
    input  logic [31:0] i_rs1_data,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_br_unsigned,
    output logic [31:0] o_pc,
    output logic        o_flush,
    output logic        o_taken,
    output logic        o_trap,
    output logic [31:0] o_trap_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] o_br_count,
    output logic [31:0] o_br_taken_count
`endif
);

    typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] trap_pc_reg, trap_pc_next;
    logic        cond;
    logic        sel_branch;
    logic        taken;
    logic [31:0] target;
    logic        misaligned;

    assign o_br_unsigned = i_ex_funct3[1];

    always_comb begin
        cond = 1'b0;
        case (i_ex_funct3)
            3'b000:  cond = i_br_equal;
            3'b001:  cond = ~i_br_equal;
            3'b100,
            3'b110:  cond = i_br_less;
            3'b101,
            3'b111:  cond = ~i_br_less;
            default: cond = 1'b0;
        endcase
    end

    // Jumps outrank a conditional branch when decode asserts more than one type.
    assign sel_branch = i_ex_is_branch & ~i_ex_is_jal & ~i_ex_is_jalr;
    assign taken      = i_ex_valid & (i_ex_is_jalr | i_ex_is_jal | (sel_branch & cond));
    assign target     = i_ex_is_jalr ? ((i_rs1_data + i_ex_imm) & ~32'h1)
                                     : (i_ex_pc + i_ex_imm);
    assign misaligned = taken & target[1];

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg   <= RUN;
            pc_reg      <= RESET_PC;
            trap_pc_reg <= 32'h0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            trap_pc_reg <= trap_pc_next;
        end
    end

    // Next-state logic; a redirect takes precedence over a stall.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        trap_pc_next = trap_pc_reg;
        case (state_reg)
            RUN: begin
                if (misaligned) begin
                    state_next   = TRAP;
                    trap_pc_next = i_ex_pc;
                end else if (taken) begin
                    pc_next = target;
                end else if (!i_stall) begin
                    pc_next = pc_reg + 32'd4;
                end
            end
            TRAP: begin
                state_next = TRAP;
            end
            default: state_next = RUN;
        endcase
    end

    // Output logic
    always_comb begin
        o_flush = 1'b0;
        o_taken = 1'b0;
        o_trap  = 1'b0;
        case (state_reg)
            RUN: begin
                o_flush = taken & ~i_reset;
                o_taken = taken & ~i_reset;
            end
            TRAP: begin
                o_trap  = 1'b1;
                o_flush = ~i_reset;
            end
            default: ;
        endcase
    end

    assign o_pc      = pc_reg;
    assign o_trap_pc = trap_pc_reg;

`ifdef BRANCH_STATS_EN
    logic [31:0] br_count_reg;
    logic [31:0] br_taken_count_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            br_count_reg       <= 32'h0;
            br_taken_count_reg <= 32'h0;
        end else if (state_reg == RUN && i_ex_valid && sel_branch) begin
            br_count_reg <= br_count_reg + 32'd1;
            if (cond) begin
                br_taken_count_reg <= br_taken_count_reg + 32'd1;
            end
        end
    end

    assign o_br_count       = br_count_reg;
    assign o_br_taken_count = br_taken_count_reg;
`endif

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

EX-stage branch resolution and PC-generation unit for the 5-stage RV32I pipeline, sitting directly downstream of the branch comparator. Decodes branch/jump type from funct3 and control bits, drives the comparator's signedness select, consumes its less/equal flags and decides taken/not-taken. Holds the fetch PC register, issues the pipeline flush on redirect, and traps on a misaligned taken target.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_stall  in  1  hazard-unit stall; hold PC when no redirect
- i_ex_valid  in  1  EX slot holds a real instruction
- i_ex_is_branch  in  1  conditional branch in EX
- i_ex_is_jal  in  1  JAL in EX
- i_ex_is_jalr  in  1  JALR in EX
- i_ex_funct3  in  3  branch condition field
- i_ex_pc  in  32  PC of EX instruction
- i_ex_imm  in  32  sign-extended immediate
- i_rs1_data  in  32  forwarded rs1 (JALR base)
- i_br_less  in  1  comparator less flag
- i_br_equal  in  1  comparator equal flag
- o_br_unsigned  out  1  signedness select to comparator
- o_pc  out  32  current fetch PC
- o_flush  out  1  kill IF/ID and ID/EX this cycle
- o_taken  out  1  EX control transfer taken
- o_trap  out  1  misaligned-target trap, sticky
- o_trap_pc  out  32  PC of trapping instruction

## Operation
- o_br_unsigned = i_ex_funct3[1], combinational.
- Condition: 000 eq; 001 !eq; 100 less; 101 !less; 110 less; 111 !less; 010/011 never taken.
- taken = i_ex_valid & (is_jal | is_jalr | (is_branch & cond)); o_taken = taken while in RUN.
- Target: branch/JAL = i_ex_pc + i_ex_imm; JALR = (i_rs1_data + i_ex_imm) & ~32'h1. Adds mod 2^32, wrap silent.
- Misaligned: taken & target[1]. Not-taken branches never trap.
- FSM states RUN, TRAP.
  - RUN: misaligned -> TRAP, o_trap_pc <= i_ex_pc, PC held, o_flush=1. Else taken -> PC <= target, o_flush=1. Else !i_stall -> PC <= PC+4. Else hold.
  - TRAP: o_trap=1, o_flush=1 every cycle, PC frozen, inputs ignored; exit only by reset.
- Redirect beats stall: taken with i_stall=1 still loads target and flushes.
- More than one of is_branch/is_jal/is_jalr set: priority jalr > jal > branch.

## Timing
- o_flush, o_taken, o_br_unsigned combinational from EX inputs, same cycle as resolution (cycle N); o_pc = target at N+1.
- Branch penalty: 2 flushed slots.
- Reset (any state, mid-redirect included): o_pc=RESET_PC, state RUN, o_trap=0, o_trap_pc=0; o_flush=0 and o_taken=0 while i_reset high.
- PC+4 wraps 32'hFFFF_FFFC -> 0.

## Configuration
- BRANCH_STATS_EN defined: adds outputs o_br_count[31:0] (valid conditional branches resolved in RUN) and o_br_taken_count[31:0] (those taken); cleared by reset, increment once per EX-valid cycle, wrap at 2^32, frozen in TRAP.
- Undefined: counters and ports absent; other behaviour identical.

## Test plan
- Reset RESET_PC=32'h100, no stall, 4 idle cycles -> o_pc 100,104,108,10C; o_flush=0.
- BEQ funct3=000, pc=0x20, imm=0x40, equal=1 -> o_flush=1, o_taken=1, next o_pc=0x60; equal=0 -> no flush, o_pc+4.
- BLTU funct3=110 -> o_br_unsigned=1, less=1 taken; BGE funct3=101, less=1 -> not taken; funct3=010 with equal=1 -> not taken.
- JALR rs1=0x1001, imm=0x4 -> target 0x1004; i_stall=1 same cycle -> redirect still occurs.
- JAL pc=0x40, imm=0x6 -> o_trap=1, o_trap_pc=0x40, o_pc frozen, o_flush held high; i_reset one cycle -> o_pc=RESET_PC, o_trap=0.
- BRANCH_STATS_EN: 3 branches (2 taken) plus 1 JAL -> o_br_count=3, o_br_taken_count=2; reset -> both 0.
